ds_decimator_fifo: RTL and testbench
====================================

# ds_decimator_fifo

Parametrised accumulate-and-dump decimator for the delta-sigma ADC. It counts the ones in the modulator's 1-bit stream over exactly OSR accepted samples, saturates the count to DATA_W bits, and pushes one word per frame into an internal first-word-fall-through FIFO. It sits between the modulator output and the downstream bus/UART reader. It replaces the vendor accumulator and FIFO cores with portable RTL and adds sample enable, saturation and overflow reporting.

## Interface
Parameters:
- OSR, 256, samples per output word; legal range 2..65536
- DATA_W, 8, output word width; legal range 1..16
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 2

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  sample strobe; bit_in is accepted only on edges where en=1
- bit_in  in  1  modulator bitstream
- rd_en  in  1  pop request; ignored when empty=1
- clr_flags  in  1  synchronous clear of sat and overflow
- dout  out  DATA_W  head of FIFO; valid while empty=0
- empty  out  1  FIFO holds 0 words
- full  out  1  FIFO holds FIFO_DEPTH words
- level  out  $clog2(FIFO_DEPTH+1)  words in FIFO
- sat  out  1  sticky: a frame result was clipped
- overflow  out  1  sticky: a frame result was dropped because the FIFO was full

## Operation
- State: sample counter idx (0..OSR-1), accumulator acc ($clog2(OSR+1) bits), FIFO storage, read/write pointers, and the sat and overflow flags.
- Accepted sample (en=1):
  - If idx < OSR-1: acc <= acc + bit_in; idx <= idx+1.
  - If idx == OSR-1 (frame end): compute sum = acc + bit_in. The result is min(sum, 2^DATA_W − 1). sat is set if sum > 2^DATA_W − 1. The result is pushed, and acc and idx are set to 0 on the same edge.
- en=0: acc and idx hold. The push logic is idle.
- Frames are exactly OSR accepted samples. There is no extra idle cycle between frames.
- FIFO is first-word-fall-through. Pop occurs when rd_en=1 and empty=0.
- Push and pop on the same edge:
  - Both succeed, including when full; level is unchanged.
  - When empty, the pop is ignored and the push succeeds.
- Push while full with no pop: the word is dropped and overflow is set. The stored contents and pointers do not change. Framing continues.
- Pointers wrap modulo FIFO_DEPTH. full and empty are derived from level, or from extra-bit pointers.
- Flags:
  - clr_flags=1 clears sat and overflow.
  - If a set event coincides with clr_flags, the set wins.
- Reset value of every output: dout=0, empty=1, full=0, level=0, sat=0, overflow=0. Internally acc=0 and idx=0.
- Reset mid-frame discards the partial frame and all FIFO contents. The first frame after release starts with the first accepted sample.

## Timing
- Frame-end push to visibility: empty deasserts and level increments on the push edge. dout shows the word in the same cycle after that edge, so latency is 0 cycles from the final sample edge.
- Pop: dout advances to the next word on the pop edge. Popping the last word sets empty=1 after the edge.
- Flags set on the offending edge and are visible the following cycle.
- Throughput: at most 1 push per OSR accepted samples. Pops can run at 1 per clk.
- No combinational path exists from rd_en to empty, full, level or dout.

## Structure
- Package ds_adc_pkg holds:
  - the log2 helper and ACC_W/PTR_W width derivation;
  - the default OSR/DATA_W/FIFO_DEPTH constants, shared with the modulator testbench.
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH) provides push/pop, dout, empty, full, level and a push_drop pulse. The top level holds the framing counter, accumulator, saturation logic and sticky flags.

## Test plan
- Default parameters, bit_in = alternating 1/0, en=1, 2 frames → 2 words of 128. The first word appears 256 edges after reset release; sat=0.
- Default parameters, bit_in=1 constant for 1 frame → word 255 and sat=1. Then clr_flags=1, followed by 1 frame of all 0 → word 0 and sat=0.
- OSR=4, bit_in pattern 1,1,0,1 with en toggling 1,0,1,0,… → 1 word of 3 after 8 clk edges; acc holds during en=0.
- FIFO_DEPTH=4, OSR=4, bit_in=1, no reads, 6 frames → level=4 and full=1 after frame 4. overflow=1 after frame 5. Reads return 4,4,4,4 and then empty=1.
- FIFO_DEPTH=4, full FIFO, rd_en=1 on the frame-end edge → level stays 4, overflow stays 0, and the read returns the oldest word.
- OSR=8, assert rst after 5 samples of 1 for 1 clk → all outputs are at reset values. The next frame of all 0 yields word 0, not 5.

Source files
------------

// File: rtl/ds_adc_pkg.sv
// rtl/ds_adc_pkg.sv - shared constants and width helpers for the delta-sigma ADC datapath
// Contents:
//   DEF_OSR, DEF_DATA_W, DEF_FIFO_DEPTH : default decimator configuration
//   log2Ceil(v)                         : ceil(log2(v)), 0 for v <= 1
//   accWidth(osr)                       : bits needed to hold a count of 0..osr
//   ptrWidth(depth)                     : FIFO address width
//   levelWidth(depth)                   : bits needed to hold a FIFO fill of 0..depth
package ds_adc_pkg;

   localparam int DEF_OSR        = 256;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FIFO_DEPTH = 16;

   function automatic int log2Ceil(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((longint'(1) << i) < longint'(v)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic int accWidth(input int osr);
      return log2Ceil(osr + 1);
   endfunction

   function automatic int ptrWidth(input int depth);
      return log2Ceil(depth);
   endfunction

   function automatic int levelWidth(input int depth);
      return log2Ceil(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO with drop reporting
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, din       : write request and data; dropped when full unless a pop happens on the same edge
//   pop             : read request; ignored when empty
//   dout            : head word, 0 while empty
//   empty, full     : fill status, derived from level
//   level           : number of stored words
//   push_drop       : pulses combinationally when the current push will be discarded
module sync_fifo_fwft
   import ds_adc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int PTR_W = ptrWidth(DEPTH),
   localparam int LVL_W = levelWidth(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [LVL_W-1:0] level,
   output logic             push_drop
);

   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             doPush;
   logic             doPop;

   assign empty     = (level == '0);
   assign full      = (level == FULL_LVL);
   assign doPop     = pop && !empty;
   // A simultaneous pop frees the head slot, so a full FIFO can still accept the push;
   // with wrPtr == rdPtr the new word lands in the slot being vacated.
   assign doPush    = push && (!full || doPop);
   assign push_drop = push && !doPush;
   // Gate the unreset storage so dout reads 0 whenever there is nothing valid.
   assign dout      = empty ? '0 : mem[rdPtr];

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= din;
      end
   end

   // Power-of-2 depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         level <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         if (doPush && !doPop) begin
            level <= level + LVL_W'(1);
         end else if (doPop && !doPush) begin
            level <= level - LVL_W'(1);
         end
      end
   end

endmodule

// File: rtl/ds_decimator_fifo.sv
// rtl/ds_decimator_fifo.sv - accumulate-and-dump decimator with saturating output and FWFT result FIFO
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   en, bit_in   : sample strobe and modulator bit; a sample is taken only when en=1
//   rd_en        : pop the FIFO head (ignored when empty)
//   clr_flags    : clear sat and overflow (a coincident set wins)
//   dout         : FIFO head, valid while empty=0
//   empty, full  : FIFO status
//   level        : words held in the FIFO
//   sat          : sticky, a frame count exceeded 2^DATA_W-1 and was clipped
//   overflow     : sticky, a frame result was dropped on a full FIFO
module ds_decimator_fifo
   import ds_adc_pkg::*;
#(
   parameter int OSR        = DEF_OSR,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic                              bit_in,
   input  logic                              rd_en,
   input  logic                              clr_flags,
   output logic [DATA_W-1:0]                 dout,
   output logic                              empty,
   output logic                              full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
   output logic                              sat,
   output logic                              overflow
);

   localparam int               ACC_W    = accWidth(OSR);
   localparam int               IDX_W    = log2Ceil(OSR);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OSR - 1);
   localparam logic [31:0]      MAX_WORD = (32'd1 << DATA_W) - 32'd1;

   logic [IDX_W-1:0]  idx;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum;
   logic              frameEnd;
   logic              clip;
   logic [DATA_W-1:0] word;
   logic              pushDrop;

   assign frameEnd = en && (idx == LAST_IDX);
   // ACC_W holds OSR itself, so the final sample never wraps the sum.
   assign sum      = acc + ACC_W'(bit_in);
   assign clip     = 32'(sum) > MAX_WORD;
   assign word     = clip ? DATA_W'(MAX_WORD) : DATA_W'(sum);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         acc      <= '0;
         sat      <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (en) begin
            if (frameEnd) begin
               idx <= '0;
               acc <= '0;
            end else begin
               idx <= idx + IDX_W'(1);
               acc <= sum;
            end
         end
         if (frameEnd && clip) begin
            sat <= 1'b1;
         end else if (clr_flags) begin
            sat <= 1'b0;
         end
         if (pushDrop) begin
            overflow <= 1'b1;
         end else if (clr_flags) begin
            overflow <= 1'b0;
         end
      end
   end

   sync_fifo_fwft #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk       (clk),
      .rst       (rst),
      .push      (frameEnd),
      .din       (word),
      .pop       (rd_en),
      .dout      (dout),
      .empty     (empty),
      .full      (full),
      .level     (level),
      .push_drop (pushDrop)
   );

endmodule

// File: tb/tb_ds_decimator_fifo.sv
// tb/tb_ds_decimator_fifo.sv - directed self-checking bench for ds_decimator_fifo
module tb_ds_decimator_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nCmp = 0;
   int nBad = 0;

   // dutA: default configuration (OSR=256, DATA_W=8, FIFO_DEPTH=16)
   logic       rstA, enA, bitA, rdA, clrA;
   logic [7:0] doutA;
   logic       emptyA, fullA, satA, ovfA;
   logic [4:0] levelA;

   // dutB: OSR=4, FIFO_DEPTH=4
   logic       rstB, enB, bitB, rdB, clrB;
   logic [7:0] doutB;
   logic       emptyB, fullB, satB, ovfB;
   logic [2:0] levelB;

   // dutC: OSR=8
   logic       rstC, enC, bitC, rdC, clrC;
   logic [7:0] doutC;
   logic       emptyC, fullC, satC, ovfC;
   logic [4:0] levelC;

   ds_decimator_fifo uDutA (
      .clk(clk), .rst(rstA), .en(enA), .bit_in(bitA), .rd_en(rdA), .clr_flags(clrA),
      .dout(doutA), .empty(emptyA), .full(fullA), .level(levelA), .sat(satA), .overflow(ovfA)
   );

   ds_decimator_fifo #(.OSR(4), .DATA_W(8), .FIFO_DEPTH(4)) uDutB (
      .clk(clk), .rst(rstB), .en(enB), .bit_in(bitB), .rd_en(rdB), .clr_flags(clrB),
      .dout(doutB), .empty(emptyB), .full(fullB), .level(levelB), .sat(satB), .overflow(ovfB)
   );

   ds_decimator_fifo #(.OSR(8), .DATA_W(8), .FIFO_DEPTH(16)) uDutC (
      .clk(clk), .rst(rstC), .en(enC), .bit_in(bitC), .rd_en(rdC), .clr_flags(clrC),
      .dout(doutC), .empty(emptyC), .full(fullC), .level(levelC), .sat(satC), .overflow(ovfC)
   );

   typedef struct {
      logic en;
      logic bitIn;
      logic rd;
      logic clr;
      int   empty;
      int   full;
      int   level;
      int   dout;
      int   sat;
      int   ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      nCmp++;
      if (act != exp) begin
         nBad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic addRow(input logic en, input logic b, input logic rd, input logic clr,
                         input int e, input int f, input int l, input int d, input int s, input int o);
      vec_t v;
      v.en = en; v.bitIn = b; v.rd = rd; v.clr = clr;
      v.empty = e; v.full = f; v.level = l; v.dout = d; v.sat = s; v.ovf = o;
      vecs.push_back(v);
   endtask

   task automatic stepA(input logic en, input logic b, input logic rd, input logic clr);
      enA = en; bitA = b; rdA = rd; clrA = clr;
      @(posedge clk); #1;
   endtask

   task automatic stepC(input logic en, input logic b);
      enC = en; bitC = b; rdC = 1'b0; clrC = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic chkAll(input string tag, input int act[6], input int exp[6]);
      chk({tag, ".dout"},     act[0], exp[0]);
      chk({tag, ".empty"},    act[1], exp[1]);
      chk({tag, ".full"},     act[2], exp[2]);
      chk({tag, ".level"},    act[3], exp[3]);
      chk({tag, ".sat"},      act[4], exp[4]);
      chk({tag, ".overflow"}, act[5], exp[5]);
   endtask

   initial begin
      int lvl;
      int fillLvl [6] = '{1, 2, 3, 4, 4, 4};

      // ---- dutB vector table (OSR=4, DEPTH=4) ----
      // en toggling, accepted bits 1,1,0,1 (bits offered while en=0 are 1 and must be ignored)
      addRow(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      addRow(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      addRow(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      addRow(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      addRow(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      addRow(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      addRow(1, 1, 0, 0, 0, 0, 1, 3, 0, 0);
      addRow(0, 1, 0, 0, 0, 0, 1, 3, 0, 0);
      addRow(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      addRow(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);   // pop on empty ignored
      // 6 frames of all ones, no reads; frame 5 drops with clr_flags high (set wins)
      for (int f = 1; f <= 6; f++) begin
         lvl = (f == 1) ? 0 : fillLvl[f-2];
         for (int s = 0; s < 3; s++)
            addRow(1, 1, 0, 0, (lvl == 0), (lvl == 4), lvl, (lvl == 0) ? 0 : 4, 0, (f == 6));
         addRow(1, 1, 0, (f == 5), 0, (fillLvl[f-1] == 4), fillLvl[f-1], 4, 0, (f >= 5));
      end
      // clear flags, then a frame 0,0,0,1 whose push coincides with a pop on a full FIFO
      addRow(0, 0, 0, 1, 0, 1, 4, 4, 0, 0);
      addRow(1, 0, 0, 0, 0, 1, 4, 4, 0, 0);
      addRow(1, 0, 0, 0, 0, 1, 4, 4, 0, 0);
      addRow(1, 0, 0, 0, 0, 1, 4, 4, 0, 0);
      addRow(1, 1, 1, 0, 0, 1, 4, 4, 0, 0);
      // drain: contents are 4,4,4,1
      addRow(0, 0, 1, 0, 0, 0, 3, 4, 0, 0);
      addRow(0, 0, 1, 0, 0, 0, 2, 4, 0, 0);
      addRow(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
      addRow(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      addRow(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);

      rstA = 1; rstB = 1; rstC = 1;
      enA = 0; bitA = 0; rdA = 0; clrA = 0;
      enB = 0; bitB = 0; rdB = 0; clrB = 0;
      enC = 0; bitC = 0; rdC = 0; clrC = 0;
      #1;
      chkAll("resetA", '{int'(doutA), int'(emptyA), int'(fullA), int'(levelA), int'(satA), int'(ovfA)},
             '{0, 1, 0, 0, 0, 0});
      chkAll("resetB", '{int'(doutB), int'(emptyB), int'(fullB), int'(levelB), int'(satB), int'(ovfB)},
             '{0, 1, 0, 0, 0, 0});
      @(posedge clk); #1;
      rstA = 0; rstB = 0; rstC = 0;

      // ---- table-driven run on dutB ----
      foreach (vecs[i]) begin
         enB = vecs[i].en; bitB = vecs[i].bitIn; rdB = vecs[i].rd; clrB = vecs[i].clr;
         @(posedge clk); #1;
         chkAll($sformatf("B[%0d]", i),
                '{int'(doutB), int'(emptyB), int'(fullB), int'(levelB), int'(satB), int'(ovfB)},
                '{vecs[i].dout, vecs[i].empty, vecs[i].full, vecs[i].level, vecs[i].sat, vecs[i].ovf});
      end
      enB = 0; rdB = 0; clrB = 0;

      // ---- dutA: alternating 1/0, two frames -> 128, 128 ----
      for (int k = 0; k < 256; k++) begin
         stepA(1, (k % 2 == 0), 0, 0);
         if (k == 254) chk("A.alt.emptyBeforeFrameEnd", emptyA, 1);
      end
      chkAll("A.alt1", '{int'(doutA), int'(emptyA), int'(fullA), int'(levelA), int'(satA), int'(ovfA)},
             '{128, 0, 0, 1, 0, 0});
      for (int k = 0; k < 256; k++) stepA(1, (k % 2 == 0), 0, 0);
      chk("A.alt2.level", levelA, 2);
      stepA(0, 0, 1, 0);
      chk("A.pop1.dout", doutA, 128);
      chk("A.pop1.level", levelA, 1);
      stepA(0, 0, 1, 0);
      chk("A.pop2.empty", emptyA, 1);

      // ---- dutA: all ones saturates, clear, then all zeros ----
      for (int k = 0; k < 256; k++) stepA(1, 1, 0, 0);
      chkAll("A.ones", '{int'(doutA), int'(emptyA), int'(fullA), int'(levelA), int'(satA), int'(ovfA)},
             '{255, 0, 0, 1, 1, 0});
      stepA(0, 0, 0, 1);
      chk("A.clr.sat", satA, 0);
      for (int k = 0; k < 256; k++) stepA(1, 0, 0, 0);
      chk("A.zeros.level", levelA, 2);
      chk("A.zeros.sat", satA, 0);
      stepA(0, 0, 1, 0);
      chk("A.zeros.dout", doutA, 0);
      chk("A.zeros.levelAfterPop", levelA, 1);
      stepA(0, 0, 0, 0);

      // ---- dutC (OSR=8): one full frame, partial frame, async reset ----
      for (int k = 0; k < 8; k++) stepC(1, 1);
      chk("C.frame.dout", doutC, 8);
      for (int k = 0; k < 5; k++) stepC(1, 1);
      #2 rstC = 1;
      #1;
      chkAll("C.rst", '{int'(doutC), int'(emptyC), int'(fullC), int'(levelC), int'(satC), int'(ovfC)},
             '{0, 1, 0, 0, 0, 0});
      @(posedge clk); #1;
      rstC = 0;
      for (int k = 0; k < 7; k++) stepC(1, 0);
      chk("C.afterRst.emptyAt7", emptyC, 1);
      stepC(1, 0);
      chk("C.afterRst.level", levelC, 1);
      chk("C.afterRst.dout", doutC, 0);
      stepC(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
